icache_fill_ctrl: RTL and testbench

ICACHE_FILL_CTRL -- requirements
Module: icache_fill_ctrl

---
 rtl/icache_fill_ctrl_if.sv | 32 +++
 rtl/icache_fill_ctrl.sv | 134 +++++++++++++
 tb/tb_icache_fill_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_fill_ctrl_if.sv
// Cache-side and memory-side signals of the icache fill controller.
// master = the controller's view, slave = the cache/memory environment's view.
interface icache_fill_ctrl_if #(
  parameter int LOG2CACHELINESIZE = 7
);
  logic                                miss_req;
  logic [31:0]                         miss_addr;
  logic                                miss_done;
  logic                                flush_req;
  logic                                flush_done;
  logic                                bus_flush;
  logic                                mem_rd_req;
  logic [31:0]                         mem_rd_addr;
  logic                                mem_rd_wait;
  logic                                mem_rd_valid;
  logic [31:0]                         mem_rd_data;
  logic [31:0]                         mem_filladdr;
  logic [2**LOG2CACHELINESIZE-1:0]     mem_filldata;
  logic                                mem_fillwe;

  modport master (
    input  miss_req, miss_addr, flush_req, mem_rd_wait, mem_rd_valid, mem_rd_data,
    output miss_done, flush_done, bus_flush, mem_rd_req, mem_rd_addr,
           mem_filladdr, mem_filldata, mem_fillwe
  );

  modport slave (
    output miss_req, miss_addr, flush_req, mem_rd_wait, mem_rd_valid, mem_rd_data,
    input  miss_done, flush_done, bus_flush, mem_rd_req, mem_rd_addr,
           mem_filladdr, mem_filldata, mem_fillwe
  );
endinterface

// File: rtl/icache_fill_ctrl.sv
// Icache line fill / flush sequencer, one read outstanding, stalls on mem_rd_wait; first read one cycle after miss,
// fill strobe one cycle after the last beat. ICACHE_FILL_CRITWORD_EN starts the beat order at the missing word.
module icache_fill_ctrl #(
  parameter int LOG2CACHELINESIZE = 7,
  parameter int LOG2CACHEDEPTH    = 6
) (
  input  logic                  mem_clk,
  input  logic                  reset,
  icache_fill_ctrl_if.master    bus
);
  localparam int NBEATS = 2**(LOG2CACHELINESIZE-5);
  localparam int WIDX   = LOG2CACHELINESIZE-5;
  localparam int OFFW   = LOG2CACHELINESIZE-3;
  localparam logic [WIDX-1:0] LAST_BEAT = WIDX'(NBEATS-1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, DONE, FLUSH} state_t;

  state_t                        state;
  logic [31:0]                   line_base;
  logic [WIDX-1:0]               start_idx;
  logic [WIDX-1:0]               beat_cnt;
  logic [NBEATS-1:0][31:0]       line_buf;
  logic [LOG2CACHEDEPTH-1:0]     flush_cnt;
  logic                          flush_pend;
  logic                          rd_req;
  logic [31:0]                   rd_addr;
  logic                          fillwe;
  logic                          miss_done;
  logic                          flush_done;
  logic                          bus_flush;

  logic [WIDX-1:0]               miss_start;
  logic [WIDX-1:0]               cur_idx;
  logic [WIDX-1:0]               next_idx;

`ifdef ICACHE_FILL_CRITWORD_EN
  assign miss_start = bus.miss_addr[LOG2CACHELINESIZE-4:2];
`else
  assign miss_start = '0;
`endif

  // Word slot is an offset from the starting word, so the order wraps inside the line.
  assign cur_idx  = start_idx + beat_cnt;
  assign next_idx = cur_idx + 1'b1;

  always_ff @(posedge mem_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      line_base  <= '0;
      start_idx  <= '0;
      beat_cnt   <= '0;
      line_buf   <= '0;
      flush_cnt  <= '0;
      flush_pend <= 1'b0;
      rd_req     <= 1'b0;
      rd_addr    <= '0;
      fillwe     <= 1'b0;
      miss_done  <= 1'b0;
      flush_done <= 1'b0;
      bus_flush  <= 1'b0;
    end else begin
      fillwe     <= 1'b0;
      miss_done  <= 1'b0;
      flush_done <= 1'b0;
      if (bus.flush_req && state != IDLE) begin
        flush_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.flush_req || flush_pend) begin
            flush_pend <= 1'b0;
            flush_cnt  <= '0;
            bus_flush  <= 1'b1;
            state      <= FLUSH;
          end else if (bus.miss_req) begin
            line_base <= {bus.miss_addr[31:OFFW], {OFFW{1'b0}}};
            start_idx <= miss_start;
            beat_cnt  <= '0;
            rd_addr   <= {bus.miss_addr[31:OFFW], miss_start, 2'b00};
            rd_req    <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (!bus.mem_rd_wait) begin
            rd_req <= 1'b0;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_rd_valid) begin
            line_buf[cur_idx] <= bus.mem_rd_data;
            if (beat_cnt == LAST_BEAT) begin
              fillwe <= 1'b1;
              state  <= WRITE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
              rd_addr  <= {line_base[31:OFFW], next_idx, 2'b00};
              rd_req   <= 1'b1;
              state    <= REQ;
            end
          end
        end
        WRITE: begin
          miss_done <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        FLUSH: begin
          if (flush_cnt == '1) begin
            bus_flush  <= 1'b0;
            flush_done <= 1'b1;
            state      <= IDLE;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_rd_req   = rd_req;
  assign bus.mem_rd_addr  = rd_addr;
  assign bus.mem_filladdr = line_base;
  assign bus.mem_filldata = line_buf;
  assign bus.mem_fillwe   = fillwe;
  assign bus.miss_done    = miss_done;
  assign bus.flush_done   = flush_done;
  assign bus.bus_flush    = bus_flush;
endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl: table of fills plus hand sequences for flush and reset corners.
module tb_icache_fill_ctrl;
  localparam int L = 7;
  localparam int D = 6;
`ifdef ICACHE_FILL_CRITWORD_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif

  logic mem_clk = 1'b0;
  logic reset   = 1'b1;
  int   n_chk   = 0;
  int   n_pass  = 0;

  icache_fill_ctrl_if #(.LOG2CACHELINESIZE(L)) ifc();

  icache_fill_ctrl #(.LOG2CACHELINESIZE(L), .LOG2CACHEDEPTH(D)) dut (
    .mem_clk (mem_clk),
    .reset   (reset),
    .bus     (ifc)
  );

  always #5 mem_clk = ~mem_clk;

  typedef struct {
    logic [31:0] addr;
    int          wait_beat;
    int          wait_cycles;
    int          flush_beat;
    logic [31:0] exp_base;
  } vec_t;

  vec_t vecs[4];

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  task automatic tick;
    @(posedge mem_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " rd_req"},    128'(ifc.mem_rd_req),   128'(0));
    chk({tag, " rd_addr"},   128'(ifc.mem_rd_addr),  128'(0));
    chk({tag, " miss_done"}, 128'(ifc.miss_done),    128'(0));
    chk({tag, " flush_done"},128'(ifc.flush_done),   128'(0));
    chk({tag, " bus_flush"}, 128'(ifc.bus_flush),    128'(0));
    chk({tag, " fillwe"},    128'(ifc.mem_fillwe),   128'(0));
    chk({tag, " filladdr"},  128'(ifc.mem_filladdr), 128'(0));
    chk({tag, " filldata"},  ifc.mem_filldata,       128'(0));
  endtask

  task automatic do_fill(input string tag, input logic [31:0] addr, input int wb, input int wc,
                         input int fb, input logic [31:0] base);
    int           start;
    logic [31:0]  ea;
    logic [127:0] eline;
    start = CRIT ? int'(addr[3:2]) : 0;
    ifc.miss_addr = addr;
    ifc.miss_req  = 1'b1;
    tick;
    ifc.miss_addr = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      ea = base + 32'(4 * ((start + k) % 4));
      chk($sformatf("%s beat%0d addr", tag, k), 128'(ifc.mem_rd_addr), 128'(ea));
      chk($sformatf("%s beat%0d req", tag, k),  128'(ifc.mem_rd_req),  128'(1));
      if (k == wb) begin
        ifc.mem_rd_wait  = 1'b1;
        ifc.mem_rd_valid = 1'b1;
        ifc.mem_rd_data  = 32'hBAD0_BAD0;
        for (int w = 0; w < wc; w++) begin
          tick;
          chk($sformatf("%s wait%0d addr", tag, w), 128'(ifc.mem_rd_addr), 128'(ea));
          chk($sformatf("%s wait%0d req", tag, w),  128'(ifc.mem_rd_req),  128'(1));
        end
        ifc.mem_rd_wait  = 1'b0;
        ifc.mem_rd_valid = 1'b0;
      end
      tick;
      chk($sformatf("%s beat%0d req drop", tag, k), 128'(ifc.mem_rd_req), 128'(0));
      ifc.mem_rd_data  = mdata(ifc.mem_rd_addr);
      ifc.mem_rd_valid = 1'b1;
      if (fb >= 0 && k >= fb) ifc.flush_req = 1'b1;
      tick;
      ifc.mem_rd_valid = 1'b0;
      ifc.flush_req    = 1'b0;
      if (k < 3) chk($sformatf("%s beat%0d no fillwe", tag, k), 128'(ifc.mem_fillwe), 128'(0));
    end
    for (int w = 0; w < 4; w++) eline[32*w +: 32] = mdata(base + 32'(4 * w));
    chk({tag, " fillwe"},    128'(ifc.mem_fillwe),   128'(1));
    chk({tag, " filladdr"},  128'(ifc.mem_filladdr), 128'(base));
    chk({tag, " filldata"},  ifc.mem_filldata,       eline);
    tick;
    chk({tag, " miss_done"}, 128'(ifc.miss_done),    128'(1));
    chk({tag, " fillwe off"},128'(ifc.mem_fillwe),   128'(0));
    ifc.miss_req = 1'b0;
    tick;
    chk({tag, " miss_done off"}, 128'(ifc.miss_done), 128'(0));
    chk({tag, " no flush yet"},  128'(ifc.bus_flush), 128'(0));
  endtask

  // Ends in the flush_done cycle; extra_at pulses flush_req at that flush cycle.
  task automatic check_flush(input string tag, input int extra_at);
    int n   = 0;
    int cnt = 0;
    while (!ifc.bus_flush && n < 10) begin
      tick;
      n++;
    end
    while (ifc.bus_flush && cnt < 200) begin
      if (cnt == extra_at) ifc.flush_req = 1'b1;
      chk($sformatf("%s no done c%0d", tag, cnt), 128'(ifc.flush_done), 128'(0));
      tick;
      ifc.flush_req = 1'b0;
      cnt++;
    end
    chk({tag, " flush cycles"}, 128'(cnt),            128'(64));
    chk({tag, " flush_done"},   128'(ifc.flush_done), 128'(1));
  endtask

  initial begin
    int done_cnt;
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int dn;
    vecs[0] = '{32'h0000_1234, -1, 0, -1, 32'h0000_1230};
    vecs[1] = '{32'h0000_FFFC,  2, 3, -1, 32'h0000_FFF0};
    vecs[2] = '{32'h8000_0008,  0, 1,  1, 32'h8000_0000};
    vecs[3] = '{32'h1234_567C,  3, 2, -1, 32'h1234_5670};

    ifc.miss_req     = 1'b0;
    ifc.miss_addr    = '0;
    ifc.flush_req    = 1'b0;
    ifc.mem_rd_wait  = 1'b0;
    ifc.mem_rd_valid = 1'b0;
    ifc.mem_rd_data  = '0;
    #2;
    chk_all_zero("reset");
    tick;
    tick;
    reset = 1'b0;
    tick;
    chk_all_zero("post reset idle");

    for (int i = 0; i < 4; i++) begin
      do_fill($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wait_beat, vecs[i].wait_cycles,
              vecs[i].flush_beat, vecs[i].exp_base);
      if (vecs[i].flush_beat >= 0) begin
        check_flush($sformatf("vec%0d flush", i), -1);
        tick;
        chk($sformatf("vec%0d done off", i), 128'(ifc.flush_done), 128'(0));
        tick;
        chk($sformatf("vec%0d merged", i),   128'(ifc.bus_flush),  128'(0));
      end
    end

    // Flush request during a flush earns exactly one more full flush.
    ifc.flush_req = 1'b1;
    tick;
    ifc.flush_req = 1'b0;
    check_flush("dbl1", 20);
    check_flush("dbl2", -1);
    tick;
    chk("dbl end done",  128'(ifc.flush_done), 128'(0));
    tick;
    chk("dbl end flush", 128'(ifc.bus_flush),  128'(0));

    // Miss and flush together in IDLE: flush wins, then the fill runs.
    ifc.miss_addr = 32'h0000_4448;
    ifc.miss_req  = 1'b1;
    ifc.flush_req = 1'b1;
    tick;
    ifc.flush_req = 1'b0;
    chk("prio bus_flush", 128'(ifc.bus_flush),  128'(1));
    chk("prio no rd_req", 128'(ifc.mem_rd_req), 128'(0));
    check_flush("prio", -1);
    do_fill("prio fill", 32'h0000_4448, -1, 0, -1, 32'h0000_4440);

    // Reset after two beats of a fill.
    ifc.miss_addr = 32'h0000_2000;
    ifc.miss_req  = 1'b1;
    tick;
    for (int k = 0; k < 2; k++) begin
      tick;
      ifc.mem_rd_data  = mdata(ifc.mem_rd_addr);
      ifc.mem_rd_valid = 1'b1;
      tick;
      ifc.mem_rd_valid = 1'b0;
    end
    chk("midfill rd_req", 128'(ifc.mem_rd_req), 128'(1));
    reset = 1'b1;
    #1;
    chk_all_zero("midfill reset");
    tick;
    ifc.miss_req = 1'b0;
    reset        = 1'b0;
    ifc.mem_rd_data  = 32'hFFFF_FFFF;
    ifc.mem_rd_valid = 1'b1;
    tick;
    ifc.mem_rd_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk_all_zero($sformatf("after reset c%0d", c));
      tick;
    end

    // Reset during a flush: no flush_done afterwards.
    ifc.flush_req = 1'b1;
    tick;
    ifc.flush_req = 1'b0;
    repeat (10) tick;
    chk("midflush active", 128'(ifc.bus_flush), 128'(1));
    reset = 1'b1;
    #1;
    chk("midflush reset bus_flush", 128'(ifc.bus_flush), 128'(0));
    tick;
    reset = 1'b0;
    dn = 0;
    for (int c = 0; c < 80; c++) begin
      tick;
      if (ifc.flush_done || ifc.bus_flush) dn++;
    end
    chk("midflush no flush activity", 128'(dn), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
